rr_switch_unit: RTL and testbench

- N-to-1 round-robin switch stage directly downstream of a bank of register-based queues.
- Inspects each queue head through its deq_rdy/deq_msg pair and grants one queue per cycle, pulsing that queue's deq_en.
- Captures the granted message into a one-entry output pipeline register.
- Forwards the registered message downstream over the same en/rdy handshake. The downstream consumer is typically the next queue's enq_en/enq_rdy/enq_msg.

---
 rtl/net_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/rr_switch_unit.sv | 43 ++++
 tb/tb_rr_switch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// net_pkg: shared helpers for switch and route units
package net_pkg;
  function automatic int src_w(input int n);
    return n == 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter whose priority advances past each grant
module rr_arbiter import net_pkg::*; #(
  parameter int num_inputs = 4,
  parameter int src_width  = src_w(num_inputs)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [num_inputs-1:0] reqs,
  input  logic                  en,
  output logic [num_inputs-1:0] grants,
  output logic [src_width-1:0]  grant_idx
);
  logic [src_width-1:0] r_prio;
  logic [src_width-1:0] w_j;
  logic                 w_found;
  always_comb begin
    grants    = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_j       = '0;
    for (int k = 0; k < num_inputs; k++) begin
      w_j = src_width'((int'(r_prio) + k) % num_inputs);
      if (en && !w_found && reqs[w_j]) begin
        w_found   = 1'b1;
        grants    = '0;
        grants[w_j] = 1'b1;
        grant_idx = w_j;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_prio <= '0;
    else if (w_found) r_prio <= grant_idx == src_width'(num_inputs - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/rr_switch_unit.sv
// rr_switch_unit: round-robin N-to-1 switch with a one-entry output register
module rr_switch_unit import net_pkg::*; #(
  parameter int data_width = 32,
  parameter int num_inputs = 4,
  parameter int src_width  = src_w(num_inputs)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [num_inputs-1:0]            recv_rdy,
  input  logic [num_inputs*data_width-1:0] recv_msg,
  output logic [num_inputs-1:0]            recv_en,
  output logic                             send_en,
  input  logic                             send_rdy,
  output logic [data_width-1:0]            send_msg,
  output logic [src_width-1:0]             send_src
);
  logic                  r_valid;
  logic [data_width-1:0] r_msg;
  logic [src_width-1:0]  r_src;
  logic                  w_accept;
  logic [num_inputs-1:0] w_grants;
  logic [src_width-1:0]  w_idx;
  assign send_en  = r_valid & send_rdy;
  assign w_accept = ~r_valid | send_en;
  assign recv_en  = w_grants;
  assign send_msg = r_msg;
  assign send_src = r_src;
  // gating with reset keeps recv_en low while reset is held, since out_valid=0 alone would accept
  rr_arbiter #(.num_inputs(num_inputs), .src_width(src_width)) u_arb (
    .clk(clk), .reset(reset), .reqs(recv_rdy), .en(w_accept & ~reset),
    .grants(w_grants), .grant_idx(w_idx)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_msg   <= '0;
      r_src   <= '0;
    end else if (|w_grants) begin
      r_valid <= 1'b1;
      r_msg   <= recv_msg[int'(w_idx)*data_width +: data_width];
      r_src   <= w_idx;
    end else if (send_en) r_valid <= 1'b0;
endmodule

// File: tb/tb_rr_switch_unit.sv
// tb_rr_switch_unit: directed and random checks against a round-robin reference model
module tb_rr_switch_unit;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   recv_rdy;
  logic [127:0] recv_msg;
  logic [3:0]   recv_en;
  logic         send_en;
  logic         send_rdy;
  logic [31:0]  send_msg;
  logic [1:0]   send_src;
  int checks = 0;
  int errors = 0;
  logic        m_valid;
  logic [31:0] m_msg;
  int          m_src, m_prio, m_g;
  logic [31:0] msgs [4];
  logic [3:0]  e_recv_en;
  logic        e_send_en;

  rr_switch_unit #(.data_width(32), .num_inputs(4)) dut (
    .clk(clk), .reset(reset), .recv_rdy(recv_rdy), .recv_msg(recv_msg), .recv_en(recv_en),
    .send_en(send_en), .send_rdy(send_rdy), .send_msg(send_msg), .send_src(send_src)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 1'b0; m_msg = '0; m_src = 0; m_prio = 0; m_g = -1;
  endtask

  task automatic set_inputs(input logic [3:0] rdy, input logic srdy);
    logic [1:0] j;
    @(negedge clk);
    recv_rdy = rdy;
    send_rdy = srdy;
    for (int i = 0; i < 4; i++) recv_msg[i*32 +: 32] = msgs[i];
    #1;
    e_send_en = m_valid && srdy;
    m_g = -1;
    if (!m_valid || e_send_en)
      for (int k = 0; k < 4; k++) begin
        j = 2'((m_prio + k) % 4);
        if (m_g < 0 && rdy[j]) m_g = int'(j);
      end
    e_recv_en = m_g < 0 ? 4'b0000 : 4'(1 << m_g);
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_g >= 0) begin
      m_valid = 1'b1; m_msg = msgs[m_g]; m_src = m_g; m_prio = (m_g + 1) % 4;
    end else if (e_send_en) m_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; recv_rdy = '0; send_rdy = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    msgs[0] = 32'h1234_5678;
    set_inputs(4'b0001, 1'b0);
    tick();
    @(negedge clk);
    recv_rdy = 4'b1111; send_rdy = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL reset_send_en got=%b exp=0", send_en); end
    checks++; if (recv_en !== 4'b0000) begin errors++; $display("FAIL reset_recv_en got=%b exp=0000", recv_en); end
    checks++; if (send_msg !== 32'h0) begin errors++; $display("FAIL reset_send_msg got=%h exp=0", send_msg); end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    set_inputs(4'b0110, 1'b1);
    checks++; if (recv_en !== 4'b0010) begin errors++; $display("FAIL reset_first_grant got=%b exp=0010", recv_en); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    msgs[2] = 32'hDEAD_BEEF;
    set_inputs(4'b0100, 1'b1);
    checks++; if (recv_en !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", recv_en); end
    tick();
    set_inputs(4'b0000, 1'b1);
    checks++; if (send_en !== 1'b1) begin errors++; $display("FAIL single_send_en got=%b exp=1", send_en); end
    checks++; if (send_msg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_msg got=%h exp=deadbeef", send_msg); end
    checks++; if (send_src !== 2'd2) begin errors++; $display("FAIL single_src got=%0d exp=2", send_src); end
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 4; i++) msgs[i] = 32'h100 + 32'(i);
    for (int k = 0; k < 8; k++) begin
      set_inputs(4'b1111, 1'b1);
      checks++; if (recv_en !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rot_grant cyc=%0d got=%b exp=%b", k, recv_en, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (send_en !== 1'b1 || send_msg !== 32'h100 + 32'((k - 1) % 4)) begin errors++; $display("FAIL rot_send cyc=%0d got=%b/%h exp=1/%h", k, send_en, send_msg, 32'h100 + 32'((k - 1) % 4)); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    msgs[0] = 32'hA5;
    set_inputs(4'b0001, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_inputs(4'b1111, 1'b0);
      checks++; if (recv_en !== 4'b0000 || send_en !== 1'b0) begin errors++; $display("FAIL bp_stall cyc=%0d recv_en=%b send_en=%b exp=0000/0", k, recv_en, send_en); end
      checks++; if (send_msg !== 32'hA5) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=a5", k, send_msg); end
      tick();
    end
    set_inputs(4'b1111, 1'b1);
    checks++; if (send_en !== 1'b1 || recv_en !== 4'b0010) begin errors++; $display("FAIL bp_release send_en=%b recv_en=%b exp=1/0010", send_en, recv_en); end
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    msgs[2] = 32'h22; msgs[0] = 32'h00; msgs[1] = 32'h11;
    set_inputs(4'b0100, 1'b1);
    tick();
    set_inputs(4'b0011, 1'b1);
    checks++; if (recv_en !== 4'b0001) begin errors++; $display("FAIL wrap_grant got=%b exp=0001", recv_en); end
    tick();
    set_inputs(4'b0011, 1'b1);
    checks++; if (recv_en !== 4'b0010) begin errors++; $display("FAIL skip_grant got=%b exp=0010", recv_en); end
    checks++; if (send_src !== 2'd0) begin errors++; $display("FAIL wrap_src got=%0d exp=0", send_src); end
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    msgs[3] = 32'hCAFE_0003;
    set_inputs(4'b1000, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_inputs(4'b0000, 1'b1);
      checks++; if (send_en !== (k == 0)) begin errors++; $display("FAIL drain_send_en cyc=%0d got=%b exp=%b", k, send_en, k == 0); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) msgs[i] = $urandom;
      set_inputs(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      checks++;
      if (recv_en !== e_recv_en || send_en !== e_send_en || send_msg !== m_msg || send_src !== 2'(m_src)) begin
        errors++;
        $display("FAIL rand cyc=%0d got recv_en=%b send_en=%b msg=%h src=%0d exp %b %b %h %0d", k, recv_en, send_en, send_msg, send_src, e_recv_en, e_send_en, m_msg, m_src);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; recv_rdy = '0; send_rdy = 1'b0; recv_msg = '0;
    for (int i = 0; i < 4; i++) msgs[i] = '0;
    model_clear();
    e_recv_en = '0; e_send_en = 1'b0;
    #1;
    checks++; if (send_en !== 1'b0 || recv_en !== 4'b0000 || send_msg !== 32'h0) begin errors++; $display("FAIL init_reset send_en=%b recv_en=%b msg=%h exp=0", send_en, recv_en, send_msg); end
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
    test_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
